// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and constants for the program-counter stage.
//   pc_state_e : boot/run/halt FSM encoding
//   pc_sel_e   : next-PC source encoding
//   PC_STEP    : sequential fetch increment in bytes
//   DEFAULT_RESET_VECTOR : default PC loaded on reset
package pc_unit_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SelSeq    = 2'd0,
        SelBranch = 2'd1,
        SelJump   = 2'd2,
        SelJr     = 2'd3
    } pc_sel_e;

    localparam int unsigned PC_STEP              = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: purely combinational next-PC candidate formation and priority select.
// Priority: jr > jump > branch_taken > sequential.
// Macro PC_ALIGN_CHECK_EN: when defined, the jr target passes through unmodified
// (misaligned targets are trapped upstream in pc_unit); otherwise jr_addr[1:0] is cleared.
// Ports:
//   pc            in  current PC
//   branch_taken  in  conditional branch resolved taken
//   branch_offset in  sign-extended word offset
//   jump          in  J/JAL-type jump
//   jump_index    in  26-bit instruction index
//   jr            in  jump-register
//   jr_addr       in  register-sourced target
//   pc_plus4      out pc + PC_STEP
//   next_pc       out selected next PC
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_target;

    assign pc_plus4 = pc + WIDTH'(PC_STEP);

`ifdef PC_ALIGN_CHECK_EN
    assign jr_target = jr_addr;
`else
    assign jr_target = jr_addr & ~WIDTH'(3);
`endif

    // Region bits come from pc_plus4 so a jump in the delay slot of a region edge lands correctly.
    assign jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    assign branch_target = pc_plus4 + (branch_offset << 2);

    always_comb begin
        sel = SelSeq;
        if (jr) begin
            sel = SelJr;
        end else if (jump) begin
            sel = SelJump;
        end else if (branch_taken) begin
            sel = SelBranch;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        unique case (sel)
            SelJr:     next_pc = jr_target;
            SelJump:   next_pc = jump_target;
            SelBranch: next_pc = branch_target;
            SelSeq:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage. Holds the PC, a boot/run/halt FSM and a
// retired-instruction counter; next-PC candidates come from pc_next_sel.
// Macro PC_ALIGN_CHECK_EN: when defined, a misaligned jr target in an active RUN
// cycle sets a sticky misalign flag and halts; otherwise misalign is tied 0.
// Ports:
//   clk, rst       in  clock, synchronous active-high reset
//   stall          in  hold PC and counter
//   halt_req       in  stop fetching (sticky until rst)
//   branch_taken, branch_offset, jump, jump_index, jr, jr_addr  in  redirect inputs
//   pc             out registered fetch address
//   pc_plus4       out pc + 4
//   pc_valid       out FSM in RUN
//   halted         out FSM in HALT
//   instret        out retired-instruction count
//   misalign       out sticky misaligned-jr flag
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned    WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             halted,
    output logic [WIDTH-1:0] instret,
    output logic             misalign
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instret_q;
    logic [WIDTH-1:0] next_pc;
    logic             running;
    logic             mis_fault;
    logic             halt_go;
    logic             advance;

    pc_next_sel #(
        .WIDTH(WIDTH)
    ) u_next_sel (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    assign running = (state_q == StRun);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    assign mis_fault = running && !stall && jr && (jr_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (mis_fault) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    assign mis_fault = 1'b0;
    assign misalign  = 1'b0;
`endif

    // halt_req is honoured even while stalled; a halting edge never retires.
    assign halt_go = running && (halt_req || mis_fault);
    assign advance = running && !stall && !halt_go;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (halt_go) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase
    end

    // Output logic
    always_comb begin
        pc_valid = (state_q == StRun);
        halted   = (state_q == StHalt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
        end else if (advance) begin
            pc_q      <= next_pc;
            instret_q <= instret_q + WIDTH'(1);
        end
    end

    assign pc      = pc_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, halt_req, branch_taken, jump, jr;
    logic [31:0] branch_offset, jr_addr;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, instret;
    logic        pc_valid, halted, misalign;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .halted        (halted),
        .instret       (instret),
        .misalign      (misalign)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, stall, halt, br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jra;
        logic [31:0] e_pc;
        logic        e_valid, e_halted;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    function automatic vec_t v(input logic r, input logic s, input logic h, input logic b,
                               input logic [31:0] o, input logic j, input logic [25:0] ix,
                               input logic jrr, input logic [31:0] ja, input logic [31:0] epc,
                               input logic ev, input logic eh, input logic [31:0] ec,
                               input logic em);
        vec_t t;
        t.rst = r; t.stall = s; t.halt = h; t.br = b; t.off = o; t.jmp = j; t.idx = ix;
        t.jr = jrr; t.jra = ja; t.e_pc = epc; t.e_valid = ev; t.e_halted = eh; t.e_cnt = ec;
        t.e_mis = em;
        return t;
    endfunction

    task automatic drive(input logic r, input logic s, input logic h, input logic b,
                         input logic [31:0] o, input logic j, input logic [25:0] ix,
                         input logic jrr, input logic [31:0] ja);
        rst = r; stall = s; halt_req = h; branch_taken = b; branch_offset = o;
        jump = j; jump_index = ix; jr = jrr; jr_addr = ja;
    endtask

    // Behavioural model: mode 0=boot, 1=run, 2=halt
    int          m_mode;
    logic [31:0] m_pc, m_cnt;
    logic        m_mis;

    task automatic model_step();
        logic bad_jr;
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_cnt = 0; m_mis = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            bad_jr = ALIGN && !stall && jr && (jr_addr % 4 != 0);
            if (halt_req) begin
                m_mode = 2;
            end else if (bad_jr) begin
                m_mode = 2;
                m_mis  = 1'b1;
            end else if (!stall) begin
                m_cnt = m_cnt + 1;
                if (jr)                m_pc = (jr_addr / 4) * 4;
                else if (jump)         m_pc = ((m_pc + 4) & 32'hF000_0000) + jump_index * 4;
                else if (branch_taken) m_pc = m_pc + 4 + branch_offset * 4;
                else                   m_pc = m_pc + 4;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Directed sequence, one row per clock edge
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,              32'h0,         0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h0,         1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h4,         1,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h8,         1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'h10,         32'h10,        1,0,3,0));
        tbl.push_back(v(0,0,0,1,32'hFFFF_FFFE,0,0,0,0,  32'hC,         1,0,4,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'h1000_0000,  32'h1000_0000, 1,0,5,0));
        tbl.push_back(v(0,0,0,1,32'h10,1,26'h100,0,0,   32'h1000_0400, 1,0,6,0));
        tbl.push_back(v(0,1,0,0,0,0,0,1,32'h40,         32'h1000_0400, 1,0,6,0));
        tbl.push_back(v(0,1,0,0,0,0,0,1,32'h40,         32'h1000_0400, 1,0,6,0));
        tbl.push_back(v(0,1,0,0,0,0,0,1,32'h40,         32'h1000_0400, 1,0,6,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'h40,         32'h40,        1,0,7,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'h8,          32'h8,         1,0,8,0));
        tbl.push_back(v(0,0,1,0,0,0,0,1,32'h100,        32'h8,         0,1,8,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'h100,        32'h8,         0,1,8,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h8,         0,1,8,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,              32'h0,         0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h0,         1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,32'hFFFF_FFFC,  32'hFFFF_FFFC, 1,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,              32'h0,         1,0,2,0));
        if (ALIGN) tbl.push_back(v(0,0,0,0,0,0,0,1,32'h46, 32'h0,  0,1,2,1));
        else       tbl.push_back(v(0,0,0,0,0,0,0,1,32'h46, 32'h44, 1,0,3,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,              32'h0,         0,0,0,0));

        drive(1,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].halt, tbl[i].br, tbl[i].off,
                  tbl[i].jmp, tbl[i].idx, tbl[i].jr, tbl[i].jra);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.pc", i),       pc,                tbl[i].e_pc);
            check($sformatf("vec%0d.pc_plus4", i), pc_plus4,          tbl[i].e_pc + 32'd4);
            check($sformatf("vec%0d.valid", i),    32'(pc_valid),     32'(tbl[i].e_valid));
            check($sformatf("vec%0d.halted", i),   32'(halted),       32'(tbl[i].e_halted));
            check($sformatf("vec%0d.instret", i),  instret,           tbl[i].e_cnt);
            check($sformatf("vec%0d.misalign", i), 32'(misalign),     32'(tbl[i].e_mis));
        end

        // Randomized run against the model, starting from a fresh reset
        drive(1,0,0,0,0,0,0,0,0);
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 59) == 0),
                  $urandom_range(0, 1),
                  32'($signed($urandom_range(0, 255)) - 128),
                  ($urandom_range(0, 5) == 0),
                  26'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            model_step();
            @(posedge clk);
            #1;
            check("rnd.pc",       pc,              m_pc);
            check("rnd.pc_plus4", pc_plus4,        m_pc + 32'd4);
            check("rnd.valid",    32'(pc_valid),   32'(m_mode == 1));
            check("rnd.halted",   32'(halted),     32'(m_mode == 2));
            check("rnd.instret",  instret,         m_cnt);
            check("rnd.misalign", 32'(misalign),   32'(m_mis));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
